// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the sequence-detector bench:
// state encoding, debug view and a counter-width helper.
package seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   // Debug view; bit_cnt is zero-extended so the struct stays fixed-size for WIDTH up to 32.
   typedef struct packed {
      state_t     state;
      logic [3:0] gap_cnt;
      logic [4:0] bit_cnt;
   } ser_dbg_t;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      if (result < 1) result = 1;
      return result;
   endfunction

endpackage

// File: rtl/seq_ser_counter.sv
// Loadable down-counter that saturates at zero and flags when it reads zero.
module seq_ser_counter #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer feeding the Moore sequence detector's serial input,
// with selectable bit order and an optional idle gap between words.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP        = 0,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             CK,
   input  logic             R,
   input  logic [WIDTH-1:0] LOAD_DATA,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   output logic             OUT_BIT,
   output logic             OUT_VALID,
   output logic             BUSY,
   output logic             DONE,
   output ser_dbg_t         DBG
);

   localparam int            CW       = clog2(WIDTH);
   localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
   localparam int            GAP_M1   = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [3:0]    GAP_LOAD = 4'(GAP_M1);
   localparam bit            HAS_GAP  = (GAP > 0);

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;
   logic             r_out_bit;
   logic             r_out_valid;
   logic             r_done;

   logic [CW-1:0]    w_bit_cnt;
   logic             w_bit_zero;
   logic [3:0]       w_gap_cnt;
   logic             w_gap_zero;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_sr_shift;

   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Handshake: a word transfers at a rising edge where LOAD_VALID and LOAD_READY
   // are both 1. LOAD_READY never looks at LOAD_VALID; an unaccepted source holds
   // its word, and LOAD_DATA is ignored outside the accepting edge.
   assign w_last   = (r_state == S_SHIFT) && w_bit_zero;
   assign w_ready  = !R && ((r_state == S_IDLE) || (w_last && !HAS_GAP));
   assign w_accept = w_ready && LOAD_VALID;

   always_comb begin
      w_sr_shift = r_sr;
      if (MSB_FIRST) w_sr_shift = {r_sr[WIDTH-2:0], 1'b0};
      else           w_sr_shift = {1'b0, r_sr[WIDTH-1:1]};
   end

   seq_ser_counter #(.W(CW)) u_bit_cnt (
      .i_clk      (CK),
      .i_rst      (R),
      .i_load     (w_accept),
      .i_load_val (BIT_LOAD),
      .i_dec      ((r_state == S_SHIFT) && !w_bit_zero),
      .o_count    (w_bit_cnt),
      .o_zero     (w_bit_zero)
   );

   seq_ser_counter #(.W(4)) u_gap_cnt (
      .i_clk      (CK),
      .i_rst      (R),
      .i_load     (w_last && HAS_GAP),
      .i_load_val (GAP_LOAD),
      .i_dec      ((r_state == S_GAP) && !w_gap_zero),
      .o_count    (w_gap_cnt),
      .o_zero     (w_gap_zero)
   );

   // OUT_BIT is registered one edge ahead, so it always shows the bit the
   // bit counter is currently accounting for.
   always_ff @(posedge CK) begin
      if (R) begin
         r_state     <= S_IDLE;
         r_sr        <= '0;
         r_out_bit   <= IDLE_LEVEL;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_SHIFT;
                  r_sr        <= LOAD_DATA;
                  r_out_bit   <= first_bit(LOAD_DATA);
                  r_out_valid <= 1'b1;
                  r_done      <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (!w_bit_zero) begin
                  r_sr      <= w_sr_shift;
                  r_out_bit <= first_bit(w_sr_shift);
                  r_done    <= (w_bit_cnt == CW'(1));
               end else if (HAS_GAP) begin
                  r_state     <= S_GAP;
                  r_out_bit   <= IDLE_LEVEL;
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b0;
               end else if (w_accept) begin
                  r_sr      <= LOAD_DATA;
                  r_out_bit <= first_bit(LOAD_DATA);
                  r_done    <= 1'b0;
               end else begin
                  r_state     <= S_IDLE;
                  r_out_bit   <= IDLE_LEVEL;
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b0;
               end
            end
            S_GAP: begin
               if (w_gap_zero) r_state <= S_IDLE;
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_bit   <= IDLE_LEVEL;
               r_out_valid <= 1'b0;
               r_done      <= 1'b0;
            end
         endcase
      end
   end

   assign LOAD_READY  = w_ready;
   assign OUT_BIT     = r_out_bit;
   assign OUT_VALID   = r_out_valid;
   assign BUSY        = (r_state != S_IDLE);
   assign DONE        = r_done;
   assign DBG.state   = r_state;
   assign DBG.gap_cnt = w_gap_cnt;
   assign DBG.bit_cnt = 5'(w_bit_cnt);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: default build (MSB first, no gap),
// a GAP=2 build and an LSB-first build share one clock and reset.
module tb_seq_bit_serializer;
   import seq_pkg::*;

   logic clk = 1'b0;
   logic R;
   always #5 clk = ~clk;

   logic [7:0] da, dg, dl;
   logic       va, vg, vl;
   logic       ra, oba, ova, busa, dna;
   logic       rg, obg, ovg, busg, dng;
   logic       rl, obl, ovl, busl, dnl;
   ser_dbg_t   dbga, dbgg, dbgl;

   int n_vec = 0;
   int n_err = 0;

   seq_bit_serializer dut_a (
      .CK(clk), .R(R), .LOAD_DATA(da), .LOAD_VALID(va), .LOAD_READY(ra),
      .OUT_BIT(oba), .OUT_VALID(ova), .BUSY(busa), .DONE(dna), .DBG(dbga)
   );

   seq_bit_serializer #(.GAP(2)) dut_g (
      .CK(clk), .R(R), .LOAD_DATA(dg), .LOAD_VALID(vg), .LOAD_READY(rg),
      .OUT_BIT(obg), .OUT_VALID(ovg), .BUSY(busg), .DONE(dng), .DBG(dbgg)
   );

   seq_bit_serializer #(.MSB_FIRST(1'b0)) dut_l (
      .CK(clk), .R(R), .LOAD_DATA(dl), .LOAD_VALID(vl), .LOAD_READY(rl),
      .OUT_BIT(obl), .OUT_VALID(ovl), .BUSY(busl), .DONE(dnl), .DBG(dbgl)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic a_idle(input string tag);
      chk({tag, ".valid"}, 32'(ova), 0);
      chk({tag, ".busy"},  32'(busa), 0);
      chk({tag, ".done"},  32'(dna), 0);
      chk({tag, ".bit"},   32'(oba), 0);
      chk({tag, ".ready"}, 32'(ra), 1);
      chk({tag, ".state"}, 32'(dbga.state), 32'(S_IDLE));
   endtask

   // Checks one 8-bit word on dut_a, MSB first. With cont=1 the source keeps
   // LOAD_VALID high and offers nxt in the last-bit cycle; other cycles carry junk.
   task automatic a_word(input string tag, input logic [7:0] w, input bit cont,
                         input logic [7:0] nxt);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s[%0d].valid", tag, i), 32'(ova), 1);
         chk($sformatf("%s[%0d].bit", tag, i),   32'(oba), 32'(w[7-i]));
         chk($sformatf("%s[%0d].done", tag, i),  32'(dna), 32'(i == 7));
         chk($sformatf("%s[%0d].ready", tag, i), 32'(ra),  32'(i == 7));
         chk($sformatf("%s[%0d].busy", tag, i),  32'(busa), 1);
         if (!cont) va = 1'b0;
         da = (i == 7) ? nxt : 8'(i * 37 + 5);
         tick();
      end
   endtask

   initial begin
      logic [7:0] exp_l;
      R  = 1'b1;
      va = 1'b0; vg = 1'b0; vl = 1'b0;
      da = 8'h00; dg = 8'h00; dl = 8'h00;
      #1;
      chk("rst.ready_forced", 32'(ra), 0);
      tick();
      chk("rst.valid", 32'(ova), 0);
      chk("rst.busy",  32'(busa), 0);
      chk("rst.done",  32'(dna), 0);
      chk("rst.bit",   32'(oba), 0);
      chk("rst.state", 32'(dbga.state), 32'(S_IDLE));
      chk("rst.bitcnt", 32'(dbga.bit_cnt), 0);
      chk("rst.gapcnt", 32'(dbgg.gap_cnt), 0);
      chk("rst.ready_held", 32'(ra), 0);
      R = 1'b0;
      #1;
      chk("rst.ready_after", 32'(ra), 1);

      // Single word 8'hB0
      va = 1'b1; da = 8'hB0;
      tick();
      a_word("s1", 8'hB0, 1'b0, 8'h00);
      a_idle("s1.end");

      // Back-to-back B0 then 0D, no bubble
      va = 1'b1; da = 8'hB0;
      tick();
      a_word("b2b0", 8'hB0, 1'b1, 8'h0D);
      a_word("b2b1", 8'h0D, 1'b0, 8'h00);
      a_idle("b2b.end");

      // GAP=2: FF then 00, second accept 11 cycles after the first
      vg = 1'b1; dg = 8'hFF;
      tick();
      for (int i = 1; i <= 22; i++) begin
         chk($sformatf("gap[%0d].valid", i), 32'(ovg), 32'((i <= 8) || (i >= 12 && i <= 19)));
         chk($sformatf("gap[%0d].bit", i),   32'(obg), 32'(i <= 8));
         chk($sformatf("gap[%0d].done", i),  32'(dng), 32'(i == 8 || i == 19));
         chk($sformatf("gap[%0d].ready", i), 32'(rg),  32'(i == 11 || i == 22));
         chk($sformatf("gap[%0d].busy", i),  32'(busg), 32'(i != 11 && i != 22));
         if (i == 1) dg = 8'h00;
         if (i == 12) vg = 1'b0;
         tick();
      end

      // LSB first: 8'b0000_1101 gives stream 1,0,1,1,0,0,0,0
      exp_l = 8'b1011_0000;
      vl = 1'b1; dl = 8'h0D;
      tick();
      vl = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb[%0d].valid", i), 32'(ovl), 1);
         chk($sformatf("lsb[%0d].bit", i),   32'(obl), 32'(exp_l[7-i]));
         chk($sformatf("lsb[%0d].done", i),  32'(dnl), 32'(i == 7));
         chk($sformatf("lsb[%0d].ready", i), 32'(rl),  32'(i == 7));
         tick();
      end
      chk("lsb.end.busy",  32'(busl), 0);
      chk("lsb.end.valid", 32'(ovl), 0);

      // Reset during the 4th bit of B0, then F0 cleanly
      va = 1'b1; da = 8'hB0;
      tick();
      va = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("mid[%0d].bit", i),  32'(oba), 32'(da[7-i]));
         chk($sformatf("mid[%0d].done", i), 32'(dna), 0);
         if (i < 3) tick();
      end
      R = 1'b1;
      #1;
      chk("mid.ready_in_rst", 32'(ra), 0);
      tick();
      chk("mid.valid", 32'(ova), 0);
      chk("mid.bit",   32'(oba), 0);
      chk("mid.busy",  32'(busa), 0);
      chk("mid.done",  32'(dna), 0);
      chk("mid.state", 32'(dbga.state), 32'(S_IDLE));
      R = 1'b0;
      #1;
      chk("mid.ready_after", 32'(ra), 1);
      va = 1'b1; da = 8'hF0;
      tick();
      a_word("mid.new", 8'hF0, 1'b0, 8'h00);
      a_idle("mid.end");

      // Stall: junk data while busy, only 3C and C3 are transmitted
      va = 1'b1; da = 8'h3C;
      tick();
      a_word("stl0", 8'h3C, 1'b1, 8'hC3);
      a_word("stl1", 8'hC3, 1'b0, 8'h00);
      a_idle("stl.end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
